// File: rtl/scrisc16_pkg.sv
// SCRISC-16 shared definitions: instruction field positions, opcodes, ALU codes
// and the packed records carried by the issue and result registers.
package scrisc16_pkg;

    localparam int OP_HI    = 15;
    localparam int OP_LO    = 12;
    localparam int RD_HI    = 11;
    localparam int RD_LO    = 9;
    localparam int RS_HI    = 8;
    localparam int RS_LO    = 6;
    localparam int RT_HI    = 5;
    localparam int RT_LO    = 3;
    localparam int IMM_HI   = 5;
    localparam int IMM_LO   = 0;
    localparam int BR_CC_HI = 11;
    localparam int BR_CC_LO = 10;
    localparam int BR_UNSIG = 9;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [1:0] OP_SHx  = 2'b01;
    localparam logic [1:0] OP_BWx  = 2'b10;
    localparam logic [3:0] OP_ADD  = 4'hC;
    localparam logic [3:0] OP_SUB  = 4'hD;
    localparam logic [3:0] OP_ADDI = 4'hE;
    localparam logic [3:0] OP_BR   = 4'hF;

    localparam logic [3:0] ALUC_ZERO = 4'b0000;
    localparam logic [3:0] ALUC_ADD  = 4'b1100;
    localparam logic [3:0] ALUC_SUB  = 4'b1101;

    typedef struct packed {
        logic [3:0]  aluc;
        logic [1:0]  alub;
        logic        unsig;
        logic        use_imm;
        logic        we;
        logic        br;
        logic        illegal;
        logic [2:0]  rd;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic [15:0] imm;
    } dec_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  aluc;
        logic [1:0]  alub;
        logic        unsig;
        logic [2:0]  rd;
        logic        we;
        logic        br;
        logic        illegal;
    } iss_t;

    typedef struct packed {
        logic [15:0] data;
        logic [2:0]  rd;
        logic        we;
        logic        br;
        logic        taken;
        logic        illegal;
    } res_t;

    function automatic logic [15:0] sext6(input logic [5:0] v);
        return {{10{v[5]}}, v};
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational SCRISC-16 instruction decode into ALU control and writeback flags.
// Zero latency; no handshake of its own.
module alu_op_decode
    import scrisc16_pkg::*;
(
    input  logic [15:0] instr,
    output dec_t        dec
);

    logic [3:0] op;
    assign op = instr[OP_HI:OP_LO];

    always_comb begin
        dec      = '0;
        dec.aluc = ALUC_ZERO;
        dec.rd   = instr[RD_HI:RD_LO];
        dec.rs   = instr[RS_HI:RS_LO];
        dec.rt   = instr[RT_HI:RT_LO];
        dec.imm  = sext6(instr[IMM_HI:IMM_LO]);
        case (op[3:2])
            OP_SHx, OP_BWx: begin
                dec.aluc = op;
                dec.we   = 1'b1;
            end
            2'b11: begin
                case (op)
                    OP_ADD: begin
                        dec.aluc = ALUC_ADD;
                        dec.we   = 1'b1;
                    end
                    OP_SUB: begin
                        dec.aluc = ALUC_SUB;
                        dec.we   = 1'b1;
                    end
                    OP_ADDI: begin
                        dec.aluc    = ALUC_ADD;
                        dec.use_imm = 1'b1;
                        dec.we      = 1'b1;
                    end
                    OP_BR: begin
                        dec.aluc  = ALUC_SUB;
                        dec.alub  = instr[BR_CC_HI:BR_CC_LO];
                        dec.unsig = instr[BR_UNSIG];
                        dec.br    = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: dec.illegal = (op != OP_NOP);
        endcase
        // r0 is hardwired; suppress any write aimed at it
        if (dec.rd == 3'd0) dec.we = 1'b0;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue (S1) and result (S2) registers around the SCRISC-16 ALU; 2-edge latency, 1/cycle.
// Full valid/ready backpressure, in_ready combinational; ALU_ISSUE_BYPASS_EN adds operand forwarding.
module alu_issue_stage
    import scrisc16_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    input  logic [15:0] in_rs_val,
    input  logic [15:0] in_rt_val,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_ALUC,
    output logic [1:0]  alu_ALUB,
    output logic        alu_Unsig,
    input  logic [15:0] alu_out,
    input  logic        alu_check,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic [2:0]  res_rd,
    output logic        res_we,
    output logic        res_br,
    output logic        res_taken,
    output logic        res_illegal
);

    dec_t        dec;
    iss_t        s1;
    iss_t        s1_next;
    res_t        s2;
    logic        s1_valid;
    logic        s1_load;
    logic        s2_load;
    logic [15:0] rs_op;
    logic [15:0] rt_op;

    alu_op_decode u_decode (
        .instr (in_instr),
        .dec   (dec)
    );

    assign s2_load  = s1_valid && (!res_valid || res_ready);
    assign in_ready = !s1_valid || !res_valid || res_ready;
    assign s1_load  = in_valid && in_ready;

`ifdef ALU_ISSUE_BYPASS_EN
    // The S1 entry is younger than S2, so its pending result takes precedence.
    function automatic logic [15:0] fwd(
        input logic [2:0]  idx,
        input logic [15:0] dflt,
        input logic        s1_hit_en,
        input logic [2:0]  s1_rd,
        input logic [15:0] s1_dat,
        input logic        s2_hit_en,
        input logic [2:0]  s2_rd,
        input logic [15:0] s2_dat
    );
        if (idx == 3'd0)                  return dflt;
        if (s1_hit_en && s1_rd == idx)    return s1_dat;
        if (s2_hit_en && s2_rd == idx)    return s2_dat;
        return dflt;
    endfunction

    assign rs_op = fwd(dec.rs, in_rs_val, s1_valid && s1.we, s1.rd, alu_out,
                       res_valid && s2.we, s2.rd, s2.data);
    assign rt_op = fwd(dec.rt, in_rt_val, s1_valid && s1.we, s1.rd, alu_out,
                       res_valid && s2.we, s2.rd, s2.data);
`else
    logic unused_idx;
    assign unused_idx = ^{dec.rs, dec.rt};
    assign rs_op      = in_rs_val;
    assign rt_op      = in_rt_val;
`endif

    always_comb begin
        s1_next         = '0;
        s1_next.a       = rs_op;
        s1_next.b       = dec.use_imm ? dec.imm : rt_op;
        s1_next.aluc    = dec.aluc;
        s1_next.alub    = dec.alub;
        s1_next.unsig   = dec.unsig;
        s1_next.rd      = dec.rd;
        s1_next.we      = dec.we;
        s1_next.br      = dec.br;
        s1_next.illegal = dec.illegal;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1        <= '0;
            res_valid <= 1'b0;
            s2        <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= 1'b1;
                s1       <= s1_next;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
            if (s2_load) begin
                res_valid    <= 1'b1;
                s2.data      <= alu_out;
                s2.rd        <= s1.rd;
                s2.we        <= s1.we;
                s2.br        <= s1.br;
                s2.taken     <= alu_check && s1.br;
                s2.illegal   <= s1.illegal;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

    assign alu_a       = s1.a;
    assign alu_b       = s1.b;
    assign alu_ALUC    = s1.aluc;
    assign alu_ALUB    = s1.alub;
    assign alu_Unsig   = s1.unsig;
    assign res_data    = s2.data;
    assign res_rd      = s2.rd;
    assign res_we      = s2.we;
    assign res_br      = s2.br;
    assign res_taken   = s2.taken;
    assign res_illegal = s2.illegal;

endmodule
